led_pattern_sequencer: RTL and testbench

Sequences the 8-LED board output through a schedule of timed light patterns: gradual fill, drain, single-LED chase and blink. It replaces a free-running single-pattern LED chaser with a controlled block. An internal prescaler turns the system clock into pattern steps. A small FSM either auto-cycles the patterns or repeats one pattern chosen by switches. It sits between the board clock/switch inputs and the `led` pins.

---
 rtl/led_seq_pkg.sv | 52 +++++
 rtl/clk_tick_gen.sv | 28 ++
 rtl/led_pattern_sequencer.sv | 82 ++++++++
 tb/tb_led_pattern_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: state encoding, pattern
// codes, phase lengths and the phase-successor rule.
package led_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHASE = 3'd3,
    ST_BLINK = 3'd4
  } state_e;

  localparam logic [1:0] MODE_FILL  = 2'd0;
  localparam logic [1:0] MODE_DRAIN = 2'd1;
  localparam logic [1:0] MODE_CHASE = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam logic [3:0] LEN_FILL  = 4'd8;
  localparam logic [3:0] LEN_DRAIN = 4'd8;
  localparam logic [3:0] LEN_CHASE = 4'd8;
  localparam logic [3:0] LEN_BLINK = 4'd4;

  function automatic state_e mode_state(input logic [1:0] mode_i);
    case (mode_i)
      MODE_FILL:  return ST_FILL;
      MODE_DRAIN: return ST_DRAIN;
      MODE_CHASE: return ST_CHASE;
      default:    return ST_BLINK;
    endcase
  endfunction

  function automatic state_e next_phase(input state_e cur, input logic auto_i,
                                        input logic [1:0] mode_i);
    if (!auto_i) return mode_state(mode_i);
    case (cur)
      ST_FILL:  return ST_DRAIN;
      ST_DRAIN: return ST_CHASE;
      ST_CHASE: return ST_BLINK;
      default:  return ST_FILL;
    endcase
  endfunction

  function automatic logic [3:0] phase_len(input state_e cur);
    case (cur)
      ST_FILL:  return LEN_FILL;
      ST_DRAIN: return LEN_DRAIN;
      ST_CHASE: return LEN_CHASE;
      default:  return LEN_BLINK;
    endcase
  endfunction

endpackage

// File: rtl/clk_tick_gen.sv
// Prescaler: asserts tick combinationally on the enabled cycle where the
// counter sits at DIV-1, then wraps to zero.
module clk_tick_gen #(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (en) cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps the 8 LEDs through FILL/DRAIN/CHASE/BLINK phases, either auto-cycling
// or repeating the switch-selected pattern, one step per prescaler tick.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       auto,
  input  logic [1:0] mode,
  output logic [7:0] led,
  output logic       busy,
  output logic       phase_done
);

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [7:0] led_q, led_d;
  logic       busy_q, busy_d;
  logic       phase_done_q, phase_done_d;
  logic [3:0] s;
  logic       run;
  logic       tick;

  // The prescaler only counts inside a phase, so IDLE->phase costs one cycle.
  assign run = en && (state_q != ST_IDLE);

  clk_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    led_d        = led_q;
    phase_done_d = 1'b0;
    s            = {1'b0, step_q} + 4'd1;
    if (state_q == ST_IDLE) begin
      if (en) state_d = auto ? ST_FILL : mode_state(mode);
    end else if (tick) begin
      step_d = s[2:0];
      case (state_q)
        ST_FILL:  led_d = 8'((9'd1 << s) - 9'd1);
        ST_DRAIN: led_d = 8'(16'h00FF << s);
        ST_CHASE: led_d = 8'd1 << (s - 4'd1);
        default:  led_d = {8{s[0]}};
      endcase
      if (s == phase_len(state_q)) begin
        phase_done_d = 1'b1;
        step_d       = '0;
        state_d      = next_phase(state_q, auto, mode);
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      led_q        <= '0;
      busy_q       <= 1'b0;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      led_q        <= led_d;
      busy_q       <= busy_d;
      phase_done_q <= phase_done_d;
    end
  end

  assign led        = led_q;
  assign busy       = busy_q;
  assign phase_done = phase_done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: a phase-level reference model predicts every output event
// (led change, phase_done pulse, busy change) and a monitor matches DUT events.
module tb_led_pattern_sequencer;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, auto = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] led;
  logic       busy, phase_done;

  logic       en2 = 1'b0;
  logic [7:0] led2;
  logic       busy2, pd2;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  typedef struct {
    int         e;
    logic [7:0] led;
    logic       pd;
    logic       busy;
  } ev_t;
  ev_t q[$];

  int         m_phase = -1;
  int         m_pos = 0;
  logic [7:0] m_led = '0;
  logic       m_busy = 1'b0;

  led_pattern_sequencer #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .auto(auto), .mode(mode),
    .led(led), .busy(busy), .phase_done(phase_done)
  );

  led_pattern_sequencer #(.DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en2), .auto(1'b1), .mode(2'd0),
    .led(led2), .busy(busy2), .phase_done(pd2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int p, input int s);
    case (p)
      0:       return 8'((1 << s) - 1);
      1:       return 8'((255 << s) & 255);
      2:       return 8'(1 << (s - 1));
      default: return (s % 2 == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  function automatic int plen(input int p);
    return (p == 3) ? 4 : 8;
  endfunction

  // Model of one clock edge with the given inputs; counts enabled phase cycles.
  task automatic model_edge(input logic e, input logic a, input logic [1:0] md);
    logic [7:0] nled = m_led;
    logic       npd = 1'b0;
    logic       nbusy = m_busy;
    int         s;
    if (m_phase < 0) begin
      if (e) begin
        m_phase = a ? 0 : int'(md);
        m_pos   = 0;
        nbusy   = 1'b1;
      end
    end else if (e) begin
      m_pos++;
      if (m_pos % DIV == 0) begin
        s    = m_pos / DIV;
        nled = pat(m_phase, s);
        if (s == plen(m_phase)) begin
          npd     = 1'b1;
          m_pos   = 0;
          m_phase = a ? (m_phase + 1) % 4 : int'(md);
        end
      end
    end
    if (nled != m_led || npd || nbusy != m_busy)
      q.push_back('{edge_n + 1, nled, npd, nbusy});
    m_led  = nled;
    m_busy = nbusy;
  endtask

  // Entered and left at a negedge.
  task automatic drive(input logic e, input logic a, input logic [1:0] md);
    en = e; auto = a; mode = md;
    model_edge(e, a, md);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    q.delete();
    #1;
    vectors++;
    if (led !== 8'h00 || busy !== 1'b0 || phase_done !== 1'b0 ||
        led2 !== 8'h00 || busy2 !== 1'b0 || pd2 !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: led=%h busy=%b pd=%b led1=%h busy1=%b pd1=%b, required all zero",
               led, busy, phase_done, led2, busy2, pd2);
    end
    @(negedge clk);
    rst = 1'b0;
    m_phase = -1; m_pos = 0; m_led = '0; m_busy = 1'b0;
  endtask

  // Monitor: every DUT event must match the oldest queued prediction.
  initial begin : monitor
    logic [7:0] p_led;
    logic       p_busy;
    ev_t        x;
    p_led = '0; p_busy = 1'b0;
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      if (rst) begin
        p_led = '0; p_busy = 1'b0;
      end else begin
        while (q.size() > 0 && q[0].e < edge_n) begin
          x = q.pop_front();
          vectors++; miscompares++;
          $display("FAIL missing_event: edge %0d led=%h pd=%b busy=%b never seen, now edge %0d",
                   x.e, x.led, x.pd, x.busy, edge_n);
        end
        if (led !== p_led || phase_done !== 1'b0 || busy !== p_busy) begin
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: edge %0d led=%h pd=%b busy=%b, required no change",
                     edge_n, led, phase_done, busy);
          end else begin
            x = q.pop_front();
            if (x.e != edge_n || x.led !== led || x.pd !== phase_done || x.busy !== busy) begin
              miscompares++;
              $display("FAIL event: got edge %0d led=%h pd=%b busy=%b, required edge %0d led=%h pd=%b busy=%b",
                       edge_n, led, phase_done, busy, x.e, x.led, x.pd, x.busy);
            end
          end
        end
        p_led = led; p_busy = busy;
      end
    end
  end

  // DIV=1 instance: a step on every enabled cycle, 28-step full cycle.
  initial begin : div1_check
    int t, u, p, s;
    logic [7:0] el;
    logic       epd;
    wait (en2 === 1'b1);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        el = 8'h00; epd = 1'b0;
      end else begin
        t = k - 1;
        u = (t - 1) % 28;
        if (u < 8)       begin p = 0; s = u + 1;  end
        else if (u < 16) begin p = 1; s = u - 7;  end
        else if (u < 24) begin p = 2; s = u - 15; end
        else             begin p = 3; s = u - 23; end
        el = pat(p, s); epd = (s == plen(p));
      end
      vectors++;
      if (led2 !== el || pd2 !== epd || busy2 !== 1'b1) begin
        miscompares++;
        $display("FAIL div1 edge %0d: led=%h pd=%b busy=%b, required led=%h pd=%b busy=1",
                 k, led2, pd2, busy2, el, epd);
      end
    end
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b0, 1'($urandom), 2'($urandom));
    vectors++;
    if (led !== 8'h00 || busy !== 1'b0 || phase_done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: led=%h busy=%b pd=%b, required 00/0/0", led, busy, phase_done);
    end

    // Auto-cycle twice; mode switches must be ignored.
    en2 = 1'b1;
    for (int i = 0; i < 2 * 28 * DIV + 12; i++) drive(1'b1, 1'b1, 2'($urandom));

    // Reset mid-phase, then repeated BLINK with a mid-phase switch to CHASE.
    apply_reset();
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 2'd3);
    drive(1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 2'd2);

    // Freeze mid-FILL for 10 cycles.
    apply_reset();
    for (int i = 0; i < 3 * DIV + 2; i++) drive(1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 2 * DIV; i++) drive(1'b1, 1'b1, 2'd0);

    // Random enables, modes and auto.
    for (int i = 0; i < 800; i++)
      drive(($urandom_range(0, 99) < 85), ($urandom_range(0, 3) == 0), 2'($urandom));
    apply_reset();
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 99) < 70), 1'($urandom), 2'($urandom));

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 2'd0);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predicted events left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
